// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the VGA timing engine:
//     - 640x480@60 default timing constants (25.175 MHz pixel clock)
//     - h_total / v_total helpers that sum the timing segments
//     - engine_state_t, the run-control state encoding
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FRONT     = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BACK      = 48;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BACK      = 33;
  localparam bit DEF_HS_POL      = 1'b0;
  localparam bit DEF_VS_POL      = 1'b0;
  localparam int DEF_COLOR_W     = 8;
  localparam int DEF_COORD_W     = 10;
  localparam int DEF_LOOKAHEAD   = 2;
  localparam int DEF_FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } engine_state_t;

  // Clocks per line.
  function automatic int h_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // Lines per frame.
  function automatic int v_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
//   Fixed-depth shift register used to align the sync/blank flags with the
//   pixel-source latency. DEPTH = 0 collapses to a wire.
// Ports:
//   clock_i  pixel clock
//   reset_i  synchronous active-low clear of every stage
//   din      WIDTH-bit value entering the line this cycle
//   dout     value that entered DEPTH cycles ago
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clock_i ^ reset_i;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clock_i) begin
      if (!reset_i) begin
        // NOTE: every stage is cleared, not just the head, so no stale
        // sync/blank flag can emerge in the cycles after a reset.
        for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
      end else begin
        stages[0] <= din;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign dout = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_engine.sv
// ---------------------------------------------------------------------------
// vga_timing_engine
//   Parametrised VGA raster generator. Pixel coordinates are requested
//   LOOKAHEAD cycles before the DAC needs the colour, so a pipelined pixel
//   source can answer in time. Start/stop is honoured only at frame edges.
// Ports:
//   clock_i, reset_i            pixel clock, synchronous active-low reset
//   enable_i                    run request (sampled at frame boundaries)
//   red_i/green_i/blue_i        colour returned LOOKAHEAD cycles after request
//   x/y_pixel_coord_o           requested column/row (0 outside active area)
//   pixel_req_o                 request is inside the active area
//   sof_o / sol_o               strobes with request (0,0) / column 0
//   frame_count_o               completed frames, wrapping
//   running_o                   engine in RUN or STOPPING
//   vga_*_o                     registered DAC colour, syncs, blank, sync_n
// ---------------------------------------------------------------------------
module vga_timing_engine
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter bit HS_POL      = DEF_HS_POL,
  parameter bit VS_POL      = DEF_VS_POL,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int LOOKAHEAD   = DEF_LOOKAHEAD,
  parameter int FRAME_CNT_W = DEF_FRAME_CNT_W
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [COLOR_W-1:0]     red_i,
  input  logic [COLOR_W-1:0]     green_i,
  input  logic [COLOR_W-1:0]     blue_i,
  output logic [COORD_W-1:0]     x_pixel_coord_o,
  output logic [COORD_W-1:0]     y_pixel_coord_o,
  output logic                   pixel_req_o,
  output logic                   sof_o,
  output logic                   sol_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic                   running_o,
  output logic [COLOR_W-1:0]     vga_red_o,
  output logic [COLOR_W-1:0]     vga_green_o,
  output logic [COLOR_W-1:0]     vga_blue_o,
  output logic                   vga_horizontal_sync_o,
  output logic                   vga_vertical_sync_o,
  output logic                   vga_blank_n_o,
  output logic                   vga_sync_n_o
);

  localparam int H_TOT = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOT = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int HC_W  = $clog2(H_TOT);
  localparam int VC_W  = $clog2(V_TOT);

  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOT - 1);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOT - 1);
  localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
  localparam logic [HC_W-1:0] HS_START = HC_W'(H_ACTIVE + H_FRONT);
  localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0] VS_START = VC_W'(V_ACTIVE + V_FRONT);
  localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [2:0]      DRAIN_LAST = 3'(LOOKAHEAD);

  engine_state_t             state_q, state_d;
  logic [HC_W-1:0]           h_cnt;
  logic [VC_W-1:0]           v_cnt;
  logic [2:0]                drain_cnt;
  logic                      frame_end;
  logic                      in_run;
  logic                      hs_act, vs_act;
  logic                      dl_hs, dl_vs, dl_de;

  assign in_run    = (state_q == RUN);
  assign frame_end = in_run && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Run control ------------------------------------------------------------
  always_comb begin
    // NOTE: the default comes first so every path assigns state_d and no
    // latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (enable_i) state_d = RUN;
      RUN:      if (frame_end && !enable_i) state_d = STOPPING;
      // Hold until the last request still in the delay line has reached
      // the DAC registers.
      STOPPING: if (drain_cnt == DRAIN_LAST) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      h_cnt         <= '0;
      v_cnt         <= '0;
      drain_cnt     <= '0;
      frame_count_o <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register sees pre-edge
      // values, independent of statement order.
      state_q <= state_d;
      // A frame end always wraps both counters to 0, so leaving RUN needs
      // no extra clearing here.
      if (in_run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end else begin
        h_cnt <= '0;
        v_cnt <= '0;
      end
      drain_cnt <= (state_q == STOPPING) ? drain_cnt + 1'b1 : '0;
      if (frame_end) frame_count_o <= frame_count_o + 1'b1;
    end
  end

  // Request stage (same cycle as the counters) ------------------------------
  assign pixel_req_o     = in_run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign x_pixel_coord_o = pixel_req_o ? COORD_W'(h_cnt) : '0;
  assign y_pixel_coord_o = pixel_req_o ? COORD_W'(v_cnt) : '0;
  assign sol_o           = pixel_req_o && (h_cnt == '0);
  assign sof_o           = sol_o && (v_cnt == '0);
  assign running_o       = (state_q != IDLE);

  // Flags are carried as "active" bits so a cleared delay line reads as
  // inactive sync regardless of polarity; polarity is applied at the output.
  assign hs_act = in_run && (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_act = in_run && (v_cnt >= VS_START) && (v_cnt < VS_END);

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (LOOKAHEAD)
  ) u_delay (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .din     ({hs_act, vs_act, pixel_req_o}),
    .dout    ({dl_hs, dl_vs, dl_de})
  );

  // Output stage -------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      vga_red_o             <= '0;
      vga_green_o           <= '0;
      vga_blue_o            <= '0;
      vga_horizontal_sync_o <= ~HS_POL;
      vga_vertical_sync_o   <= ~VS_POL;
      vga_blank_n_o         <= 1'b0;
    end else begin
      vga_horizontal_sync_o <= dl_hs ? HS_POL : ~HS_POL;
      vga_vertical_sync_o   <= dl_vs ? VS_POL : ~VS_POL;
      vga_blank_n_o         <= dl_de;
      vga_red_o             <= dl_de ? red_i   : '0;
      vga_green_o           <= dl_de ? green_i : '0;
      vga_blue_o            <= dl_de ? blue_i  : '0;
    end
  end

  assign vga_sync_n_o = 1'b0;

endmodule

// File: tb/tb_vga_timing_engine.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_engine
//   Two engines share clock, reset and enable:
//     [0] 16/2/3/2 x 8/1/2/2, LOOKAHEAD 2, active-low syncs
//     [1]  4/1/1/1 x 3/1/1/1, LOOKAHEAD 0, active-high syncs
//   A reference model tracks each engine as a position within the frame and
//   derives column/row/sync/blank arithmetically; a pipelined pixel source
//   answers requests. Every output is compared on each falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_engine;

  localparam int N = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;

  int cfg_ha [N] = '{16, 4};
  int cfg_hf [N] = '{2, 1};
  int cfg_hs [N] = '{3, 1};
  int cfg_hb [N] = '{2, 1};
  int cfg_va [N] = '{8, 3};
  int cfg_vf [N] = '{1, 1};
  int cfg_vs [N] = '{2, 1};
  int cfg_vb [N] = '{2, 1};
  int cfg_hpol [N] = '{0, 1};
  int cfg_vpol [N] = '{0, 1};
  int cfg_la [N] = '{2, 0};

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic [7:0] red_i [N], green_i [N], blue_i [N];
  logic [5:0] x_o [N], y_o [N];
  logic       req_o [N], sof_o [N], sol_o [N], run_o [N];
  logic [3:0] fc_o [N];
  logic [7:0] vr_o [N], vg_o [N], vb_o [N];
  logic       hs_o [N], vs_o [N], bn_o [N], sn_o [N];

  always #5 clock_i = ~clock_i;

  vga_timing_engine #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .COORD_W(6),
    .LOOKAHEAD(2), .FRAME_CNT_W(4)
  ) u_med (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .red_i(red_i[0]), .green_i(green_i[0]), .blue_i(blue_i[0]),
    .x_pixel_coord_o(x_o[0]), .y_pixel_coord_o(y_o[0]),
    .pixel_req_o(req_o[0]), .sof_o(sof_o[0]), .sol_o(sol_o[0]),
    .frame_count_o(fc_o[0]), .running_o(run_o[0]),
    .vga_red_o(vr_o[0]), .vga_green_o(vg_o[0]), .vga_blue_o(vb_o[0]),
    .vga_horizontal_sync_o(hs_o[0]), .vga_vertical_sync_o(vs_o[0]),
    .vga_blank_n_o(bn_o[0]), .vga_sync_n_o(sn_o[0])
  );

  vga_timing_engine #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .COORD_W(6),
    .LOOKAHEAD(0), .FRAME_CNT_W(4)
  ) u_small (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .red_i(red_i[1]), .green_i(green_i[1]), .blue_i(blue_i[1]),
    .x_pixel_coord_o(x_o[1]), .y_pixel_coord_o(y_o[1]),
    .pixel_req_o(req_o[1]), .sof_o(sof_o[1]), .sol_o(sol_o[1]),
    .frame_count_o(fc_o[1]), .running_o(run_o[1]),
    .vga_red_o(vr_o[1]), .vga_green_o(vg_o[1]), .vga_blue_o(vb_o[1]),
    .vga_horizontal_sync_o(hs_o[1]), .vga_vertical_sync_o(vs_o[1]),
    .vga_blank_n_o(bn_o[1]), .vga_sync_n_o(sn_o[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state: mode, position within frame, drain countdown,
  // completed frames, and an 8-deep history of request-stage expectations
  // (index 0 = this cycle, k = k cycles ago).
  int mode [N], pos [N], drain [N], frames [N];
  int h_de [N][8], h_hs [N][8], h_vs [N][8], h_x [N][8], h_y [N][8];

  // Pixel source history: what the DUT requested k cycles ago.
  int s_req [N][8], s_x [N][8], s_y [N][8];
  logic [7:0] salt_r, salt_g, salt_b;

  task automatic check(input string tag, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] cycle=%0d got=%0h expected=%0h",
               tag, idx, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] src_r(input int x, input int y);
    return 8'(x) ^ salt_r;
  endfunction
  function automatic logic [7:0] src_g(input int x, input int y);
    return 8'(y) ^ salt_g;
  endfunction
  function automatic logic [7:0] src_b(input int x, input int y);
    return 8'(3 * x + y) ^ salt_b;
  endfunction

  task automatic model_step(input int i, input logic rst, input logic en);
    int ht, ft, x, y, hs0, vs0;
    ht = cfg_ha[i] + cfg_hf[i] + cfg_hs[i] + cfg_hb[i];
    ft = ht * (cfg_va[i] + cfg_vf[i] + cfg_vs[i] + cfg_vb[i]);
    if (!rst) begin
      mode[i] = M_IDLE; pos[i] = 0; drain[i] = 0; frames[i] = 0;
      for (int k = 0; k < 8; k++) begin
        h_de[i][k] = 0; h_hs[i][k] = 0; h_vs[i][k] = 0;
        h_x[i][k] = 0; h_y[i][k] = 0;
      end
      return;
    end
    case (mode[i])
      M_IDLE: if (en) begin mode[i] = M_RUN; pos[i] = 0; end
      M_RUN: begin
        if (pos[i] == ft - 1) begin
          frames[i]++;
          pos[i] = 0;
          if (!en) begin mode[i] = M_STOP; drain[i] = cfg_la[i] + 1; end
        end else begin
          pos[i]++;
        end
      end
      default: begin
        drain[i]--;
        if (drain[i] == 0) mode[i] = M_IDLE;
      end
    endcase
    for (int k = 7; k > 0; k--) begin
      h_de[i][k] = h_de[i][k-1]; h_hs[i][k] = h_hs[i][k-1];
      h_vs[i][k] = h_vs[i][k-1]; h_x[i][k] = h_x[i][k-1];
      h_y[i][k] = h_y[i][k-1];
    end
    if (mode[i] == M_RUN) begin
      x = pos[i] % ht;
      y = pos[i] / ht;
      hs0 = cfg_ha[i] + cfg_hf[i];
      vs0 = cfg_va[i] + cfg_vf[i];
      h_de[i][0] = int'(x < cfg_ha[i] && y < cfg_va[i]);
      h_hs[i][0] = int'(x >= hs0 && x < hs0 + cfg_hs[i]);
      h_vs[i][0] = int'(y >= vs0 && y < vs0 + cfg_vs[i]);
      h_x[i][0] = x;
      h_y[i][0] = y;
    end else begin
      h_de[i][0] = 0; h_hs[i][0] = 0; h_vs[i][0] = 0;
      h_x[i][0] = 0; h_y[i][0] = 0;
    end
  endtask

  task automatic compare_all();
    int o, de0;
    for (int i = 0; i < N; i++) begin
      o   = cfg_la[i] + 1;
      de0 = h_de[i][0];
      check("pixel_req", i, 32'(req_o[i]), 32'(de0));
      check("x_coord", i, 32'(x_o[i]), de0 != 0 ? h_x[i][0] : 0);
      check("y_coord", i, 32'(y_o[i]), de0 != 0 ? h_y[i][0] : 0);
      check("sof", i, 32'(sof_o[i]),
            32'(de0 != 0 && h_x[i][0] == 0 && h_y[i][0] == 0));
      check("sol", i, 32'(sol_o[i]), 32'(de0 != 0 && h_x[i][0] == 0));
      check("running", i, 32'(run_o[i]), 32'(mode[i] != M_IDLE));
      check("frame_count", i, 32'(fc_o[i]), frames[i] % 16);
      check("blank_n", i, 32'(bn_o[i]), 32'(h_de[i][o]));
      check("hsync", i, 32'(hs_o[i]),
            h_hs[i][o] != 0 ? cfg_hpol[i] : 1 - cfg_hpol[i]);
      check("vsync", i, 32'(vs_o[i]),
            h_vs[i][o] != 0 ? cfg_vpol[i] : 1 - cfg_vpol[i]);
      check("red", i, 32'(vr_o[i]),
            h_de[i][o] != 0 ? 32'(src_r(h_x[i][o], h_y[i][o])) : 0);
      check("green", i, 32'(vg_o[i]),
            h_de[i][o] != 0 ? 32'(src_g(h_x[i][o], h_y[i][o])) : 0);
      check("blue", i, 32'(vb_o[i]),
            h_de[i][o] != 0 ? 32'(src_b(h_x[i][o], h_y[i][o])) : 0);
      check("sync_n", i, 32'(sn_o[i]), 0);
    end
  endtask

  // Pipelined pixel source: answers a request LOOKAHEAD cycles later and
  // drives junk when there is no request to answer.
  task automatic drive_source();
    int la;
    for (int i = 0; i < N; i++) begin
      for (int k = 7; k > 0; k--) begin
        s_req[i][k] = s_req[i][k-1]; s_x[i][k] = s_x[i][k-1];
        s_y[i][k] = s_y[i][k-1];
      end
      s_req[i][0] = int'(req_o[i]);
      s_x[i][0]   = int'(x_o[i]);
      s_y[i][0]   = int'(y_o[i]);
      la = cfg_la[i];
      if (s_req[i][la] != 0) begin
        red_i[i]   = src_r(s_x[i][la], s_y[i][la]);
        green_i[i] = src_g(s_x[i][la], s_y[i][la]);
        blue_i[i]  = src_b(s_x[i][la], s_y[i][la]);
      end else begin
        red_i[i]   = 8'($urandom);
        green_i[i] = 8'($urandom);
        blue_i[i]  = 8'($urandom);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock_i);
    for (int i = 0; i < N; i++) model_step(i, reset_i, enable_i);
    @(negedge clock_i);
    compare_all();
    drive_source();
    cyc++;
  endtask

  initial begin
    int sof_cnt, sol_cnt, budget;
    salt_r = 8'($urandom);
    salt_g = 8'($urandom);
    salt_b = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      red_i[i] = '0; green_i[i] = '0; blue_i[i] = '0;
      for (int k = 0; k < 8; k++) begin
        s_req[i][k] = 0; s_x[i][k] = 0; s_y[i][k] = 0;
      end
    end
    reset_i  = 1'b0;
    enable_i = 1'b0;

    // Reset, then idle with enable low.
    repeat (4) cycle();
    reset_i = 1'b1;
    repeat (40) cycle();
    check("idle_running", 0, 32'(run_o[0]), 0);
    check("idle_blank_n", 1, 32'(bn_o[1]), 0);

    // Continuous run: count strobes over fixed windows.
    enable_i = 1'b1;
    repeat (50) cycle();
    sof_cnt = 0;
    sol_cnt = 0;
    for (int c = 0; c < 598; c++) begin
      cycle();
      if (c < 420 && sof_o[1]) sof_cnt++;
      if (sol_o[0]) sol_cnt++;
    end
    check("small_sof_per_420", 1, sof_cnt, 10);
    check("med_sol_per_598", 0, sol_cnt, 16);

    // Drop enable mid-frame on line 5 of the medium engine.
    budget = 0;
    while (!(mode[0] == M_RUN && pos[0] / 23 == 5) && budget < 400) begin
      cycle();
      budget++;
    end
    check("wait_line5_timeout", 0, 32'(budget >= 400), 0);
    enable_i = 1'b0;
    repeat (400) cycle();
    check("stopped_running", 0, 32'(run_o[0]), 0);
    check("stopped_running", 1, 32'(run_o[1]), 0);

    // Randomised enable toggling with occasional resets.
    enable_i = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 149) == 0) enable_i = ~enable_i;
      reset_i = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    // Reset in the middle of a line, then restart with enable held high.
    reset_i  = 1'b1;
    enable_i = 1'b1;
    budget = 0;
    while (!(mode[0] == M_RUN && pos[0] % 23 == 8 && pos[0] / 23 == 4)
           && budget < 1500) begin
      cycle();
      budget++;
    end
    check("wait_midline_timeout", 0, 32'(budget >= 1500), 0);
    reset_i = 1'b0;
    cycle();
    check("reset_blank_n", 0, 32'(bn_o[0]), 0);
    check("reset_req", 0, 32'(req_o[0]), 0);
    reset_i = 1'b1;
    cycle();
    check("restart_sof", 0, 32'(sof_o[0]), 1);
    check("restart_sof", 1, 32'(sof_o[1]), 1);
    repeat (400) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
